// File: rtl/cache_pkg.sv
// Arbiter-local definitions for the icache/dcache RAM arbiter.
package cache_pkg;

  // Default number of back-to-back dcache completions tolerated while a fetch waits.
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arbstate_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared RAM-side types used by the cache-control blocks.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM handshake status reported back to the arbiter each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: dcache has priority, a starvation counter bounds fetch deferral.
module mem_arbiter
  import cpu_types_pkg::*;
  import cache_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  // icache side
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  // dcache side
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  // RAM side
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arbstate_t           state, state_nxt;
  logic [STARVE_W-1:0] starve, starve_nxt;

  // Read data is shared; each side only samples it in its completing cycle.
  assign iload = ramload;
  assign dload = ramload;

  // State and starvation counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  // Next-state, starvation update and combinational RAM/wait outputs.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;

    unique case (state)
      IDLE: begin
        if (!iREN) begin
          starve_nxt = '0;
        end
        if ((dREN || dWEN) && (!iREN || (starve < STARVE_LIM))) begin
          state_nxt = DGRANT;
        end else if (iREN) begin
          state_nxt = IGRANT;
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          // Fetch withdrawn: release the RAM without completing.
          state_nxt = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramstate == ACCESS) begin
            iwait      = 1'b0;
            state_nxt  = IDLE;
            starve_nxt = '0;
          end
        end
      end

      DGRANT: begin
        ramaddr = daddr;
        if (!(dREN || dWEN)) begin
          state_nxt = IDLE;
        end else begin
          // A write takes precedence when both strobes are raised.
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == ACCESS) begin
            dwait     = 1'b0;
            state_nxt = IDLE;
            if (iREN && (starve < STARVE_LIM)) begin
              starve_nxt = starve + STARVE_W'(1);
            end
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  typedef struct {
    logic        side;   // 1 = icache, 0 = dcache
    logic [31:0] addr;
    logic        wen;
    logic [31:0] store;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ncomp  = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard whenever a side completes and compares the RAM transaction.
  task automatic monitor();
    exp_t e;
    if (!iwait || !dwait) begin
      ncomp++;
      chk("single_completion", 32'(iwait ^ dwait), 32'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=completion expected=none");
      end else begin
        e = sb.pop_front();
        chk("sb_side", 32'(!iwait), 32'(e.side));
        chk("sb_addr", ramaddr, e.addr);
        chk("sb_wen", 32'(ramWEN), 32'(e.wen));
        if (e.wen) chk("sb_store", ramstore, e.store);
        else if (e.side) chk("sb_iload", iload, ramload);
        else chk("sb_dload", dload, ramload);
      end
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cyc();
    monitor();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ramstate_t ws[4];
    int start;

    // Reset with a fetch already requested
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramstate = ACCESS; ramload = 32'h1234_5678;
    #2;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramaddr", ramaddr, 32'd0);
    @(posedge CLK); #1;
    chk("rst_hold_ramREN", 32'(ramREN), 32'd0);

    // First fetch after reset: one arbitration cycle, then completes
    nRST = 1'b1;
    sb.push_back('{1'b1, 32'h40, 1'b0, 32'h0});
    settle();
    chk("arb_ramREN", 32'(ramREN), 32'd0);
    chk("arb_iwait", 32'(iwait), 32'd1);
    cyc();
    chk("ig_ramREN", 32'(ramREN), 32'd1);
    chk("ig_ramaddr", ramaddr, 32'h40);
    chk("ig_iwait", 32'(iwait), 32'd0);
    cyc();
    iREN = 1'b0;
    settle();
    chk("ig_idle_ramREN", 32'(ramREN), 32'd0);
    cyc();

    // Simultaneous requests: dcache first, icache after one idle cycle
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; ramload = 32'hA5A5_0001;
    sb.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    sb.push_back('{1'b1, 32'h44, 1'b0, 32'h0});
    settle();
    cyc();
    chk("sim_d_ramaddr", ramaddr, 32'h100);
    chk("sim_d_dwait", 32'(dwait), 32'd0);
    chk("sim_d_iwait", 32'(iwait), 32'd1);
    cyc();
    dREN = 1'b0;
    settle();
    chk("sim_gap_ramREN", 32'(ramREN), 32'd0);
    cyc();
    chk("sim_i_ramaddr", ramaddr, 32'h44);
    chk("sim_i_iwait", 32'(iwait), 32'd0);
    cyc();
    iREN = 1'b0;
    settle();
    cyc();

    // Wait states on a dcache read: BUSY, BUSY, ERROR, ACCESS
    ws[0] = BUSY; ws[1] = BUSY; ws[2] = ERROR; ws[3] = ACCESS;
    dREN = 1'b1; daddr = 32'h180; ramload = 32'h0BAD_F00D; ramstate = BUSY;
    sb.push_back('{1'b0, 32'h180, 1'b0, 32'h0});
    settle();
    cyc();
    for (int k = 0; k < 4; k++) begin
      ramstate = ws[k];
      settle();
      chk("ws_dwait", 32'(dwait), (k == 3) ? 32'd0 : 32'd1);
      chk("ws_ramREN", 32'(ramREN), 32'd1);
      chk("ws_ramaddr", ramaddr, 32'h180);
      cyc();
    end
    dREN = 1'b0;
    settle();
    cyc();

    // Write path: dWEN wins over dREN
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; ramstate = ACCESS;
    sb.push_back('{1'b0, 32'h200, 1'b1, 32'hDEAD_BEEF});
    settle();
    cyc();
    chk("wr_ramWEN", 32'(ramWEN), 32'd1);
    chk("wr_ramREN", 32'(ramREN), 32'd0);
    chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("wr_dwait", 32'(dwait), 32'd0);
    cyc();
    dREN = 1'b0; dWEN = 1'b0;
    settle();
    cyc();

    // Abort: fetch withdrawn while the RAM is busy
    iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY;
    settle();
    cyc();
    chk("ab_busy_ramREN", 32'(ramREN), 32'd1);
    chk("ab_busy_iwait", 32'(iwait), 32'd1);
    cyc();
    iREN = 1'b0;
    settle();
    chk("ab_drop_ramREN", 32'(ramREN), 32'd0);
    chk("ab_drop_iwait", 32'(iwait), 32'd1);
    cyc();
    chk("ab_idle_ramREN", 32'(ramREN), 32'd0);
    chk("ab_idle_iwait", 32'(iwait), 32'd1);
    cyc();

    // Starvation: fetch and writes held continuously -> 4 writes, fetch, 4 writes, fetch
    iREN = 1'b1; iaddr = 32'h400; dWEN = 1'b1; daddr = 32'h500;
    dstore = 32'hCAFE_F00D; ramstate = ACCESS; ramload = 32'h7777_0000;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 32'h500, 1'b1, 32'hCAFE_F00D});
      sb.push_back('{1'b1, 32'h400, 1'b0, 32'h0});
    end
    start = ncomp;
    for (int c = 0; c < 100 && (ncomp - start) < 10; c++) begin
      settle();
      cyc();
    end
    iREN = 1'b0; dWEN = 1'b0;
    chk("starve_completions", 32'(ncomp - start), 32'd10);
    settle();
    cyc();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-RAM arbiter between the icache and dcache, on the cache-control side of the core. Accepts instruction fetches (iREN) and data reads/writes (dREN/dWEN), grants one at a time to the single RAM port, and holds that grant until the RAM reports ACCESS. Data requests have priority; a starvation counter bounds how long a pending fetch can be deferred.

## Interface
- STARVE_MAX, 4: consecutive dcache completions allowed while iREN is pending before the icache is forced next (≥1).
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low only in the cycle the icache transfer completes.
- iload  out  32  instruction data, passthrough of ramload.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache address.
- dstore  in  32  dcache write data.
- dwait  out  1  low only in the cycle the dcache transfer completes.
- dload  out  32  data, passthrough of ramload.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- States: IDLE, IGRANT, DGRANT. Registered state plus starve counter, clog2(STARVE_MAX+1) bits.
- IDLE: no RAM strobes, ramaddr=0, ramstore=0. Next state:
  - DGRANT if (dREN|dWEN) and (!iREN or starve<STARVE_MAX).
  - Else IGRANT if iREN.
  - Else stay in IDLE.
- IGRANT: ramREN=1, ramaddr=iaddr.
  - ramstate==ACCESS: iwait=0, then IDLE.
  - iREN dropped: abort, strobes low this cycle, then IDLE.
- DGRANT: ramaddr=daddr.
  - dWEN=1 drives ramWEN=1, ramstore=dstore. dWEN wins if dWEN and dREN are both high.
  - Else ramREN=1.
  - ACCESS: dwait=0, then IDLE.
  - Both dREN and dWEN dropped: abort, then IDLE.
- BUSY, FREE or ERROR while granted: keep grant and outputs, wait stays high. ERROR is a retry.
- iwait=0 only in IGRANT with ACCESS. dwait=0 only in DGRANT with ACCESS. Otherwise 1, whether or not the side is requesting.
- Starve counter, updated on the clock edge:
  - DGRANT completes with iREN high: increment, saturating at STARVE_MAX.
  - IGRANT completes: clear.
  - IDLE with iREN low: clear.
- Requesters hold address, data and strobe stable while their wait is high. Changing address mid-grant is passed through unlatched.
- Reset state:
  - Registers: state=IDLE, starve=0.
  - Outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
  - Asserting nRST mid-grant drops the RAM strobes immediately.

## Timing
- Arbitration costs one IDLE cycle. The grant is driven starting the next cycle.
- Uncontended access with ACCESS in the first grant cycle: request seen at cycle N, wait low at N+1, state back to IDLE at N+2.
- Each additional BUSY cycle adds one cycle of latency.
- Back-to-back transfers are spaced by at least one IDLE cycle.
- Wait outputs and RAM strobes are combinational from state and inputs. No cycle delay on ramstate→wait.
- iload and dload are combinational passthroughs of ramload. They are valid only in the completing cycle.

## Structure
- cpu_types_pkg holds the shared RAM-side definitions: ramstate_t, word_t.
- cache_pkg holds the arbiter-local definitions: arbstate_t (IDLE/IGRANT/DGRANT) and the default STARVE_MAX.
- No sub-module is needed; the block is one FSM module.
- The top level connects the arbiter between the ccif icache/dcache modports and the RAM.

## Test plan
- Reset: nRST low with iREN=1 → ramREN=0, ramWEN=0, iwait=1, dwait=1. Release, ramstate=ACCESS → ramREN=1, ramaddr=iaddr=0x40 one cycle later, with iwait=0 that cycle.
- Simultaneous request: iREN=1 and dREN=1, daddr=0x100 → DGRANT first; dwait=0 on ACCESS. IGRANT follows after one IDLE cycle.
- Starvation, STARVE_MAX=4: iREN held high while dWEN is continuously asserted → exactly 4 dcache writes complete, then the icache is granted. Counter returns to 0.
- Wait states: DGRANT read with ramstate BUSY,BUSY,ERROR,ACCESS → dwait high for 3 cycles, then low. Address and ramREN stay stable throughout.
- Write path: dWEN=1, dREN=1, dstore=0xDEADBEEF, daddr=0x200 → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- Abort: IGRANT with BUSY, then iREN drops → ramREN=0 the same cycle, IDLE next cycle, no iwait=0 pulse.
